ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe.sv | 131 +++++++++++++
 tb/tb_ctrl_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined carrier for decoded control bundles.
// Each stage after decode holds one bundle plus a valid bit. Stalls back
// up toward decode, flushes clear a stage outright, and a stage that stops
// receiving data while its successor keeps moving emits a bubble.
// Optional build macro CTRL_PIPE_PERF_EN adds saturating bubble and flush
// counters; without it those ports and their logic do not exist.
module ctrl_pipe #(
    parameter int W = 8,
    parameter int STAGES = 3,
    parameter logic [STAGES*W-1:0] STAGE_MASK = {(STAGES*W){1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         sig_d,
    input  logic                 valid_d,
    input  logic [STAGES-1:0]    stall,
    input  logic [STAGES-1:0]    flush,
    output logic [STAGES*W-1:0]  sig_q,
    output logic [STAGES-1:0]    valid_q,
    output logic                 stall_d
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [31:0]          bubble_cnt,
    output logic [31:0]          flush_cnt
`endif
);

    // Effective hold per stage: any stall at or beyond a stage freezes it.
    logic [STAGES-1:0] hold_s;

    // Suffix-OR of the stall vector, walked from the last stage toward decode.
    always_comb begin
        logic acc;
        acc    = 1'b0;
        hold_s = {STAGES{1'b0}};
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc       = acc | stall[k];
            hold_s[k] = acc;
        end
    end

    // Decode holds exactly when stage 0 holds; no register in this path.
    assign stall_d = hold_s[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [W-1:0] MASK_K = STAGE_MASK[k*W +: W];

        logic         src_valid_s;
        logic [W-1:0] src_sig_s;
        logic         valid_r;
        logic [W-1:0] sig_r;

        if (k == 0) begin : g_head
            assign src_valid_s = valid_d;
            assign src_sig_s   = sig_d;
        end else begin : g_body
            // A frozen predecessor feeds a bubble rather than a duplicate of itself.
            always_comb begin
                if (hold_s[k-1]) begin
                    src_valid_s = 1'b0;
                    src_sig_s   = {W{1'b0}};
                end else begin
                    src_valid_s = valid_q[k-1];
                    src_sig_s   = sig_q[(k-1)*W +: W];
                end
            end
        end

        // Stage register: flush beats hold beats load; invalid or masked bits store as zero.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_r <= 1'b0;
                sig_r   <= {W{1'b0}};
            end else if (flush[k]) begin
                valid_r <= 1'b0;
                sig_r   <= {W{1'b0}};
            end else if (!hold_s[k]) begin
                valid_r <= src_valid_s;
                sig_r   <= src_valid_s ? (src_sig_s & MASK_K) : {W{1'b0}};
            end else begin
                valid_r <= valid_r;
                sig_r   <= sig_r;
            end
        end

        assign valid_q[k]        = valid_r;
        assign sig_q[k*W +: W]   = sig_r;
    end

`ifdef CTRL_PIPE_PERF_EN
    logic        tail_bubble_s;
    logic [31:0] bubble_cnt_r;
    logic [31:0] flush_cnt_r;

    function automatic logic [31:0] popcount(input logic [STAGES-1:0] v);
        logic [31:0] n;
        n = 32'd0;
        for (int i = 0; i < STAGES; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    // The last stage takes an empty slot on this edge without being flushed.
    always_comb begin
        tail_bubble_s = !flush[STAGES-1] && !hold_s[STAGES-1]
                        && !g_stage[STAGES-1].src_valid_s;
    end

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_r <= 32'd0;
            flush_cnt_r  <= 32'd0;
        end else begin
            bubble_cnt_r <= sat_add(bubble_cnt_r, {31'd0, tail_bubble_s});
            flush_cnt_r  <= sat_add(flush_cnt_r, popcount(flush & valid_q));
        end
    end

    assign bubble_cnt = bubble_cnt_r;
    assign flush_cnt  = flush_cnt_r;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe (W=8, STAGES=3). Two instances share
// stimulus: one with the full mask, one with mask {03,1F,FF}. A stage-level
// reference model computes expected contents from the pipeline rules.
module tb_ctrl_pipe;
    localparam int W = 8;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sig_d;
    logic         valid_d;
    logic [S-1:0] stall;
    logic [S-1:0] flush;
    logic [S*W-1:0] sig_q, sig_q_m;
    logic [S-1:0]   valid_q, valid_q_m;
    logic           stall_d, stall_d_m;
`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] bubble_cnt, flush_cnt, bubble_cnt_m, flush_cnt_m;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state: index 0 = full mask instance, 1 = masked instance
    logic         mv [2][S];
    logic [W-1:0] ms [2][S];
    logic [W-1:0] mask [2][S];
    longint       m_bubble;
    longint       m_flush;

    always #5 clk = ~clk;

    ctrl_pipe #(.W(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .sig_d(sig_d), .valid_d(valid_d),
        .stall(stall), .flush(flush), .sig_q(sig_q), .valid_q(valid_q),
        .stall_d(stall_d)
`ifdef CTRL_PIPE_PERF_EN
        , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
    );

    ctrl_pipe #(.W(W), .STAGES(S), .STAGE_MASK(24'h03_1F_FF)) dut_m (
        .clk(clk), .rst(rst), .sig_d(sig_d), .valid_d(valid_d),
        .stall(stall), .flush(flush), .sig_q(sig_q_m), .valid_q(valid_q_m),
        .stall_d(stall_d_m)
`ifdef CTRL_PIPE_PERF_EN
        , .bubble_cnt(bubble_cnt_m), .flush_cnt(flush_cnt_m)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < S; k++) begin
                mv[m][k] = 1'b0;
                ms[m][k] = 8'h00;
            end
        end
        m_bubble = 0;
        m_flush  = 0;
    endtask

    // one clock edge of the pipeline rules, applied to both models
    task automatic model_edge(input logic [W-1:0] sd, input logic vd,
                              input logic [S-1:0] st, input logic [S-1:0] fl);
        logic         ov [S];
        logic [W-1:0] os [S];
        logic         hold [S];
        logic         sv;
        logic [W-1:0] ss;
        for (int k = 0; k < S; k++) hold[k] = ((st >> k) != 3'd0);
        m_flush = m_flush + $countones(fl & {mv[0][2], mv[0][1], mv[0][0]});
        if (m_flush > 64'hFFFF_FFFF) m_flush = 64'hFFFF_FFFF;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < S; k++) begin
                ov[k] = mv[m][k];
                os[k] = ms[m][k];
            end
            for (int k = 0; k < S; k++) begin
                if (k == 0) begin
                    sv = vd; ss = sd;
                end else if (hold[k-1]) begin
                    sv = 1'b0; ss = 8'h00;
                end else begin
                    sv = ov[k-1]; ss = os[k-1];
                end
                if (fl[k]) begin
                    mv[m][k] = 1'b0; ms[m][k] = 8'h00;
                end else if (!hold[k]) begin
                    mv[m][k] = sv;
                    ms[m][k] = sv ? (ss & mask[m][k]) : 8'h00;
                    if (m == 0 && k == S - 1 && !sv) m_bubble = m_bubble + 1;
                end
            end
        end
        if (m_bubble > 64'hFFFF_FFFF) m_bubble = 64'hFFFF_FFFF;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid"},   {61'd0, valid_q},   {61'd0, mv[0][2], mv[0][1], mv[0][0]});
        check({tag, ".sig"},     {40'd0, sig_q},     {40'd0, ms[0][2], ms[0][1], ms[0][0]});
        check({tag, ".valid_m"}, {61'd0, valid_q_m}, {61'd0, mv[1][2], mv[1][1], mv[1][0]});
        check({tag, ".sig_m"},   {40'd0, sig_q_m},   {40'd0, ms[1][2], ms[1][1], ms[1][0]});
`ifdef CTRL_PIPE_PERF_EN
        check({tag, ".bubble_cnt"}, {32'd0, bubble_cnt}, m_bubble);
        check({tag, ".flush_cnt"},  {32'd0, flush_cnt},  m_flush);
`endif
    endtask

    // drive one cycle: stall_d checked before the edge, state checked after it
    task automatic cyc(input string tag, input logic [W-1:0] sd, input logic vd,
                       input logic [S-1:0] st, input logic [S-1:0] fl);
        sig_d = sd; valid_d = vd; stall = st; flush = fl;
        #1;
        check({tag, ".stall_d"}, {63'd0, stall_d}, {63'd0, (st != 3'd0)});
        @(posedge clk);
        model_edge(sd, vd, st, fl);
        #1;
        compare_all(tag);
    endtask

    initial begin
        logic [31:0] fl_before;
        for (int k = 0; k < S; k++) mask[0][k] = 8'hFF;
        mask[1][0] = 8'hFF; mask[1][1] = 8'h1F; mask[1][2] = 8'h03;
        model_reset();
        rst = 1'b1; sig_d = 8'h00; valid_d = 1'b0; stall = 3'd0; flush = 3'd0;
        #12;
        compare_all("reset");
        rst = 1'b0;

        // stream 11,22,33: stage 2 shows them on edges 3,4,5
        cyc("s1", 8'h11, 1'b1, 3'd0, 3'd0);
        cyc("s2", 8'h22, 1'b1, 3'd0, 3'd0);
        cyc("s3", 8'h33, 1'b1, 3'd0, 3'd0);
        check("stream.valid3", {61'd0, valid_q}, 64'h7);
        check("stream.sig2_c3", {56'd0, sig_q[16 +: 8]}, 64'h11);
        cyc("s4", 8'h00, 1'b0, 3'd0, 3'd0);
        check("stream.sig2_c4", {56'd0, sig_q[16 +: 8]}, 64'h22);
        cyc("s5", 8'h00, 1'b0, 3'd0, 3'd0);
        check("stream.sig2_c5", {56'd0, sig_q[16 +: 8]}, 64'h33);

        // back-pressure with A1/B2/C3 preloaded
        cyc("bp_f0", 8'hC3, 1'b1, 3'd0, 3'd0);
        cyc("bp_f1", 8'hB2, 1'b1, 3'd0, 3'd0);
        cyc("bp_f2", 8'hA1, 1'b1, 3'd0, 3'd0);
        cyc("bp_s0", 8'hEE, 1'b1, 3'b010, 3'd0);
        cyc("bp_s1", 8'hEE, 1'b1, 3'b010, 3'd0);
        check("bp.stage0", {56'd0, sig_q[0 +: 8]}, 64'hA1);
        check("bp.stage1", {56'd0, sig_q[8 +: 8]}, 64'hB2);
        check("bp.stage2", {56'd0, sig_q[16 +: 8]}, 64'h00);
        check("bp.valid",  {61'd0, valid_q}, 64'h3);

        // flush beats stall on stage 0
        cyc("fs_ld", 8'h5A, 1'b1, 3'd0, 3'd0);
        cyc("fs_fl", 8'h77, 1'b1, 3'b001, 3'b001);
        check("flush_stall.v0", {63'd0, valid_q[0]}, 64'h0);
        check("flush_stall.s0", {56'd0, sig_q[0 +: 8]}, 64'h00);

        // masking on the second instance
        cyc("m0", 8'hFF, 1'b1, 3'd0, 3'd0);
        cyc("m1", 8'hFF, 1'b1, 3'd0, 3'd0);
        cyc("m2", 8'hFF, 1'b1, 3'd0, 3'd0);
        check("mask.stages", {40'd0, sig_q_m}, 64'h03_1F_FF);

        // flush of all valid stages
        fl_before = 32'd0;
`ifdef CTRL_PIPE_PERF_EN
        fl_before = flush_cnt;
`endif
        cyc("fall", 8'h44, 1'b1, 3'd0, 3'b111);
        check("flush_all.valid", {61'd0, valid_q}, 64'h0);
`ifdef CTRL_PIPE_PERF_EN
        check("flush_all.cnt", {32'd0, flush_cnt}, {32'd0, fl_before + 32'd3});
`endif

        // asynchronous reset between edges with the pipe full
        cyc("r0", 8'h01, 1'b1, 3'd0, 3'd0);
        cyc("r1", 8'h02, 1'b1, 3'd0, 3'd0);
        cyc("r2", 8'h03, 1'b1, 3'd0, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("areset.valid", {61'd0, valid_q}, 64'h0);
        check("areset.sig",   {40'd0, sig_q},   64'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc("refill0", 8'h9C, 1'b1, 3'd0, 3'd0);
        check("refill.first", {40'd0, sig_q}, 64'h00_00_9C);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [S-1:0] st, fl;
            st = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            fl = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            cyc("rand", 8'($urandom), 1'($urandom), st, fl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
